// File: rtl/spike_rate_encoder.sv
// rtl/spike_rate_encoder.sv - accumulate-and-carry rate encoder driving LIF neuron spike inputs
// Loaded intensities persist across runs; each run emits WINDOW registered spike vectors.
module spike_rate_encoder #(
  parameter int CHANNELS = 4,
  parameter int VALUE_W  = 4,
  parameter int WINDOW   = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int SW = $clog2(WINDOW + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [CW-1:0]       load_chan,
  input  logic [VALUE_W-1:0]  load_value,
  input  logic                start,
  input  logic                pause,
  output logic [CHANNELS-1:0] spikes,
  output logic                spike_valid,
  output logic                busy,
  output logic                done,
  output logic [SW-1:0]       step_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [SW-1:0] LAST_STEP = SW'(WINDOW - 1);

  state_e              state_q, state_d;
  logic [VALUE_W-1:0]  value_q [CHANNELS];
  logic [VALUE_W-1:0]  value_d [CHANNELS];
  logic [VALUE_W-1:0]  acc_q   [CHANNELS];
  logic [VALUE_W-1:0]  acc_d   [CHANNELS];
  logic [VALUE_W:0]    sum     [CHANNELS];
  logic [CHANNELS-1:0] spikes_q, spikes_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;
  logic [SW-1:0]       step_q, step_d;
  logic                load_fire;

  assign load_fire = load_valid && ready_q && (int'(load_chan) < CHANNELS);

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sum[c] = {1'b0, acc_q[c]} + {1'b0, value_q[c]};
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    acc_d    = acc_q;
    spikes_d = '0;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    step_d   = step_q;

    if (load_fire) begin
      value_d[load_chan] = load_value;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          step_d  = '0;
          for (int c = 0; c < CHANNELS; c++) begin
            acc_d[c] = '0;
          end
        end
      end
      S_RUN: begin
        if (!pause) begin
          // The carry out of each accumulator is that channel's spike for this step.
          for (int c = 0; c < CHANNELS; c++) begin
            spikes_d[c] = sum[c][VALUE_W];
            acc_d[c]    = sum[c][VALUE_W-1:0];
          end
          valid_d = 1'b1;
          step_d  = step_q + SW'(1);
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Ready stays low through the cycle that shows the done pulse.
    ready_d = (state_d == S_IDLE) && (state_q != S_DONE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      spikes_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      step_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        value_q[c] <= '0;
        acc_q[c]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      spikes_q <= spikes_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      step_q   <= step_d;
      for (int c = 0; c < CHANNELS; c++) begin
        value_q[c] <= value_d[c];
        acc_q[c]   <= acc_d[c];
      end
    end
  end

  assign load_ready  = ready_q;
  assign spikes      = spikes_q;
  assign spike_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign step_count  = step_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb/tb_spike_rate_encoder.sv - directed self-checking bench for spike_rate_encoder
// Expected spike vectors come from the floor(N*v/2^W) identity, queued per run.
module tb_spike_rate_encoder;
  localparam int CH  = 4;
  localparam int VW  = 4;
  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       reset, load_valid, load_ready, start, pause;
  logic       spike_valid, busy, done;
  logic [1:0] load_chan;
  logic [3:0] load_value, spikes;
  logic [4:0] step_count;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] sb[$];
  int         mv[CH];

  always #5 clk = ~clk;

  spike_rate_encoder #(.CHANNELS(CH), .VALUE_W(VW), .WINDOW(WIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_chan  (load_chan),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .spikes     (spikes),
    .spike_valid(spike_valid),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int v);
    logic [1:0] c2;
    logic [3:0] v4;
    c2 = ch[1:0];
    v4 = v[3:0];
    chk("load_ready_before_load", load_ready, 1);
    load_valid = 1'b1;
    load_chan  = c2;
    load_value = v4;
    step();
    load_valid = 1'b0;
    mv[ch] = v;
  endtask

  task automatic push_run();
    logic [3:0] v;
    for (int i = 0; i < WIN; i++) begin
      v = '0;
      for (int c = 0; c < CH; c++) begin
        if (((i + 1) * mv[c]) / (1 << VW) > (i * mv[c]) / (1 << VW)) v[c] = 1'b1;
      end
      sb.push_back(v);
    end
  endtask

  task automatic do_run(input string tag, input int pause_at, input int plen, input bit inject);
    int steps = 0;
    int pcnt = 0;
    int last;
    int cnt[CH];
    logic [3:0] e;
    bit pz, ev;
    last = WIN + 1 + plen;
    foreach (cnt[c]) cnt[c] = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    load_valid = 1'b0;
    chk({tag, "_busy_at_start"}, busy, 1);
    chk({tag, "_ready_at_start"}, load_ready, 0);
    for (int cyc = 1; cyc <= last; cyc++) begin
      pz = (steps == pause_at) && (pcnt < plen);
      pause = pz;
      if (inject && cyc == 4) begin
        load_valid = 1'b1;
        load_chan  = 2'd0;
        load_value = 4'd9;
        start      = 1'b1;
      end
      step();
      pause = 1'b0;
      load_valid = 1'b0;
      start = 1'b0;
      if (pz) pcnt++;
      ev = !pz && (steps < WIN);
      chk({tag, "_spike_valid"}, spike_valid, ev);
      if (ev) begin
        if (sb.size() == 0) begin
          chk({tag, "_sb_underflow"}, sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("%s_spikes_step%0d", tag, steps), spikes, e);
          for (int c = 0; c < CH; c++) cnt[c] += int'(spikes[c]);
        end
        steps++;
      end else begin
        chk({tag, "_spikes_idle"}, spikes, 0);
      end
      chk($sformatf("%s_done_cyc%0d", tag, cyc), done, (cyc == last));
      chk({tag, "_step_count"}, step_count, steps);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ready_low"}, load_ready, 0);
    end
    chk({tag, "_sb_left"}, sb.size(), 0);
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s_count_ch%0d", tag, c), cnt[c], (WIN * mv[c]) / (1 << VW));
    end
    step();
    chk({tag, "_done_after"}, done, 0);
    chk({tag, "_ready_after"}, load_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_step_hold"}, step_count, WIN);
    step();
    chk({tag, "_no_extra_run"}, busy, 0);
    chk({tag, "_no_extra_valid"}, spike_valid, 0);
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    load_chan = '0;
    load_value = '0;
    start = 1'b0;
    pause = 1'b0;
    foreach (mv[c]) mv[c] = 0;
    step();
    step();
    reset = 1'b0;
    chk("rst_spikes", spikes, 0);
    chk("rst_valid", spike_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", step_count, 0);
    chk("rst_ready", load_ready, 1);

    load(0, 4);
    push_run();
    do_run("t1_ch0_4", -1, 0, 1'b0);

    load(0, 8);
    load(1, 15);
    load(2, 0);
    load(3, 1);
    push_run();
    do_run("t2_mix", -1, 0, 1'b0);

    load(0, 4);
    push_run();
    do_run("t3_pause", 5, 3, 1'b0);

    push_run();
    do_run("t4_inject", -1, 0, 1'b1);
    push_run();
    do_run("t4_rerun_old", -1, 0, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    chk("t5_step_before_reset", step_count, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_spikes", spikes, 0);
    chk("t5_valid", spike_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_step", step_count, 0);
    chk("t5_ready", load_ready, 1);
    foreach (mv[c]) mv[c] = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t5_no_done", done, 0);
    end
    push_run();
    do_run("t5_rerun_zero", -1, 0, 1'b0);

    chk("t6_ready", load_ready, 1);
    load_valid = 1'b1;
    load_chan  = 2'd2;
    load_value = 4'd5;
    mv[2] = 5;
    push_run();
    do_run("t6_load_start", -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Stimulus-side companion to the LIF neuron tile. It converts per-channel intensity values into deterministic rate-coded spike trains that drive the neuron's `x` spike inputs. Each run lasts a fixed window of timesteps. Values are loaded through a valid/ready port and persist across runs. Encoding is accumulate-and-carry: over 2^VALUE_W steps, channel c fires exactly value[c] spikes.

## Interface
Parameters:
- CHANNELS, 4, number of spike outputs; matches the neuron input count.
- VALUE_W, 4, intensity width per channel; also the accumulator width.
- WINDOW, 16, timesteps per run; legal range 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- load_valid  in  1  load request for one channel value.
- load_ready  out  1  high only in IDLE.
- load_chan  in  clog2(CHANNELS)  target channel; indices ≥ CHANNELS are ignored.
- load_value  in  VALUE_W  intensity to store.
- start  in  1  begins a run; only honoured in IDLE.
- pause  in  1  freezes the run while high.
- spikes  out  CHANNELS  registered spike vector, one bit per channel.
- spike_valid  out  1  high when `spikes` holds the result of a timestep.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at the end of a run.
- step_count  out  clog2(WINDOW+1)  number of timesteps completed in the current run.

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - State goes to IDLE.
  - All value registers and accumulators go to 0.
  - spikes=0, spike_valid=0, done=0, busy=0, step_count=0.
  - load_ready=1 in the first cycle after reset.
- Load:
  - A load is accepted on an edge with load_valid && load_ready.
  - It writes value[load_chan] <= load_value.
  - Loads presented outside IDLE are not accepted and have no effect.
- IDLE:
  - start=1 clears all accumulators and step_count, then moves to RUN.
  - A load and a start in the same cycle are both accepted, and the run uses the newly loaded value.
- RUN, on each edge with pause=0, for every channel c:
  - sum = acc[c] + value[c], computed at VALUE_W+1 bits.
  - spikes[c] <= sum[VALUE_W] (the carry); acc[c] <= sum[VALUE_W-1:0].
  - spike_valid <= 1; step_count increments.
- RUN, on each edge with pause=1:
  - spikes <= 0 and spike_valid <= 0.
  - Accumulators and step_count hold their values.
- RUN exit: the edge that completes step WINDOW also moves the state to DONE.
- DONE: lasts one cycle.
  - done=1, spike_valid=0, spikes=0.
  - step_count holds WINDOW.
  - Next state is IDLE.
- Back in IDLE: step_count keeps its last value until the next start.
- start is ignored in RUN and DONE; no restart and no queuing.
- Spike count identity: after N completed steps with accumulators starting at 0, channel c has fired exactly floor(N·value[c] / 2^VALUE_W) spikes.
- Boundary values:
  - value=0 never fires.
  - value=2^VALUE_W−1 fires on every step except step 0.
- Reset is honoured in any state, including mid-run and during pause. It aborts the run with no done pulse and clears the stored values.

## Timing
- Every output is registered; there is no combinational path from input to output.
- Run timing, with start sampled at edge k:
  - busy=1 from edge k.
  - The first spike vector appears after edge k+1.
  - With no pauses, spike_valid is high for cycles k+1 through k+WINDOW.
  - done is high in cycle k+WINDOW+1.
  - load_ready returns high in cycle k+WINDOW+2.
- Each paused cycle extends this schedule by one cycle.
- Spikes for step i are presented in the cycle after step i is computed, and remain valid for exactly one cycle.
- Downstream expectation: the neuron samples `spikes` on the edge following the one that registers them, gated by spike_valid.

## Test plan
- Load ch0=4, start, no pause → ch0 fires at steps 3, 7, 11, 15 (4 spikes); done pulses exactly WINDOW+1 cycles after start; other channels stay silent.
- Load ch0=8, ch1=15, ch2=0, ch3=1, run 16 steps → spike counts are 8, 15, 0, 1:
  - ch0 fires on odd steps;
  - ch1 fires on every step except step 0;
  - ch3 fires only at step 15.
- Load ch0=4, start, hold pause high for 3 cycles at step 5 → spike_valid drops for those 3 cycles; firing steps are unchanged; done is delayed by 3 cycles.
- Assert load_valid with ch0=9 during RUN → load_ready=0 and value unchanged; a later run still produces the old spike count. Assert start during RUN → ignored, no extra run.
- Assert reset at step 7 of a run → next cycle shows IDLE, spikes=0, busy=0, no done pulse, step_count=0. Rerun with ch0 unloaded → zero spikes.
- Present a load of ch2=5 and start in the same cycle → the run produces 5 spikes on ch2 over 16 steps.
